// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU op-code constants, FSM state encoding and op classification helpers.
// The op-code constants match those used by the upstream ALU control decoder.
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] f);
    return (f == ALU_SLL) || (f == ALU_SRL) || (f == ALU_SRA);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] f);
    case (f)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_shift_step.sv
// Combinational shifter used both as the per-cycle step of the iterative shifter
// and as the full barrel shifter in the fast build.
module alu_shift_step #(
  parameter int XLEN = 32,
  parameter int AW   = 6
) (
  input  logic [XLEN-1:0] value_i,
  input  logic [AW-1:0]   amount_i,
  input  logic            dir_left_i,
  input  logic            arith_i,
  output logic [XLEN-1:0] value_o
);

  always_comb begin
    if (dir_left_i)
      value_o = value_i << amount_i;
    else if (arith_i)
      value_o = XLEN'($signed(value_i) >>> amount_i);
    else
      value_o = value_i >> amount_i;
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes, registered result and branch flags.
// Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts; otherwise shifts iterate SHIFT_STEP bits/cycle.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      field,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam int AW  = SHW + 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            lt_q, lt_d, ltu_q, ltu_d, illegal_q, illegal_d;

  logic [SHW-1:0]  shamt;
  logic            op_lt, op_ltu;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] sh_val, sh_out;
  logic [AW-1:0]   sh_amt;
  logic            sh_left, sh_arith;
  logic            accept;

  assign shamt  = op_b[SHW-1:0];
  assign op_lt  = $signed(op_a) < $signed(op_b);
  assign op_ltu = op_a < op_b;
  assign accept = in_valid && (state_q == ST_IDLE) && !flush;

`ifdef ALU_FAST_SHIFT_EN
  assign sh_val   = op_a;
  assign sh_amt   = {1'b0, shamt};
  assign sh_left  = (field == ALU_SLL);
  assign sh_arith = (field == ALU_SRA);
`else
  localparam logic [AW-1:0] STEP = AW'(SHIFT_STEP);

  logic [AW-1:0] rem_q, rem_d, rem_next;
  logic          dir_q, dir_d, arith_q, arith_d;

  // Last step may be shorter than SHIFT_STEP when the remainder is not a multiple.
  assign sh_amt   = (rem_q >= STEP) ? STEP : rem_q;
  assign rem_next = rem_q - sh_amt;
  assign sh_val   = result_q;
  assign sh_left  = dir_q;
  assign sh_arith = arith_q;
`endif

  alu_shift_step #(.XLEN(XLEN), .AW(AW)) u_shift (
    .value_i    (sh_val),
    .amount_i   (sh_amt),
    .dir_left_i (sh_left),
    .arith_i    (sh_arith),
    .value_o    (sh_out)
  );

  always_comb begin
    alu_res = '0;
    case (field)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, op_lt};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_ltu};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = sh_out;
`else
      // Only a zero shift amount completes without visiting SHIFT.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
`endif
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;
    illegal_d = illegal_q;
`ifndef ALU_FAST_SHIFT_EN
    rem_d     = rem_q;
    dir_d     = dir_q;
    arith_d   = arith_q;
`endif
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            lt_d      = op_lt;
            ltu_d     = op_ltu;
            illegal_d = !is_legal_op(field);
            result_d  = alu_res;
            state_d   = ST_DONE;
`ifndef ALU_FAST_SHIFT_EN
            if (is_shift_op(field) && (shamt != '0)) begin
              state_d = ST_SHIFT;
              rem_d   = {1'b0, shamt};
              dir_d   = (field == ALU_SLL);
              arith_d = (field == ALU_SRA);
            end
`endif
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        ST_SHIFT: begin
          result_d = sh_out;
          rem_d    = rem_next;
          if (rem_next == '0) state_d = ST_DONE;
        end
`endif
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
      illegal_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      rem_q     <= '0;
      dir_q     <= 1'b0;
      arith_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
      illegal_q <= illegal_d;
`ifndef ALU_FAST_SHIFT_EN
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      arith_q   <= arith_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (default iterative build, SHIFT_STEP=1).
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  field = 4'b0000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, lt, ltu, illegal;

  int checks = 0;
  int failures = 0;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .field     (field),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    field = f; op_a = a; op_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
    checks++; if ({lt, ltu, illegal} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {lt, ltu, illegal}); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_hs got=%b%b exp=01", out_valid, in_ready); end
  endtask

  task automatic test_arith();
    int lat;
    accept(4'b0000, 32'hFFFF_FFFF, 32'h1);
    wait_done(lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if (result !== 32'h0 || zero !== 1'b1) begin failures++; $display("FAIL add_result got=%h z=%b exp=0 z=1", result, zero); end
    checks++; if ({lt, ltu} !== 2'b10) begin failures++; $display("FAIL add_flags got=%b exp=10", {lt, ltu}); end
    release_result();
    accept(4'b1000, 32'd5, 32'd7);
    wait_done(lat);
    checks++; if (result !== 32'hFFFF_FFFE || zero !== 1'b0) begin failures++; $display("FAIL sub_result got=%h exp=fffffffe", result); end
    checks++; if ({lt, ltu} !== 2'b11) begin failures++; $display("FAIL sub_flags got=%b exp=11", {lt, ltu}); end
    release_result();
  endtask

  task automatic test_compare();
    int lat;
    accept(4'b0010, 32'h8000_0000, 32'h1);
    wait_done(lat);
    checks++; if (result !== 32'h1) begin failures++; $display("FAIL slt_result got=%h exp=1", result); end
    checks++; if ({lt, ltu} !== 2'b10) begin failures++; $display("FAIL slt_flags got=%b exp=10", {lt, ltu}); end
    release_result();
    accept(4'b0011, 32'h8000_0000, 32'h1);
    wait_done(lat);
    checks++; if (result !== 32'h0 || zero !== 1'b1) begin failures++; $display("FAIL sltu_result got=%h exp=0", result); end
    checks++; if ({lt, ltu} !== 2'b10) begin failures++; $display("FAIL sltu_flags got=%b exp=10", {lt, ltu}); end
    release_result();
  endtask

  task automatic test_logic();
    logic [3:0]  fl [3] = '{4'b0100, 4'b0110, 4'b0111};
    logic [31:0] ex [3] = '{32'h0000_0FF0, 32'h0000_FFF0, 32'h0000_F000};
    int lat;
    for (int i = 0; i < 3; i++) begin
      accept(fl[i], 32'h0000_F0F0, 32'h0000_FF00);
      wait_done(lat);
      checks++; if (result !== ex[i] || lat !== 1) begin failures++; $display("FAIL logic_%0d got=%h lat=%0d exp=%h lat=1", i, result, lat, ex[i]); end
      release_result();
    end
  endtask

  task automatic test_shift();
    logic [3:0]  fl [4] = '{4'b1101, 4'b0101, 4'b0001, 4'b0101};
    logic [31:0] a  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1234};
    logic [31:0] b  [4] = '{32'd31, 32'd31, 32'd4, 32'd32};
    logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'h1, 32'h10, 32'h1234};
    int lexp [4] = '{32, 32, 5, 1};
    int lat, le;
    for (int i = 0; i < 4; i++) begin
      accept(fl[i], a[i], b[i]);
      wait_done(lat);
      le = FAST ? 1 : lexp[i];
      checks++; if (result !== ex[i]) begin failures++; $display("FAIL shift_%0d_result got=%h exp=%h", i, result, ex[i]); end
      checks++; if (lat !== le) begin failures++; $display("FAIL shift_%0d_latency got=%0d exp=%0d", i, lat, le); end
      release_result();
    end
  endtask

  task automatic test_illegal();
    int lat;
    accept(4'b1001, 32'h55, 32'h22);
    wait_done(lat);
    checks++; if (illegal !== 1'b1 || result !== 32'h0 || lat !== 1) begin failures++; $display("FAIL illegal got=%b res=%h lat=%0d exp=1 0 1", illegal, result, lat); end
    release_result();
    accept(4'b0000, 32'h1, 32'h1);
    wait_done(lat);
    checks++; if (illegal !== 1'b0 || result !== 32'h2) begin failures++; $display("FAIL illegal_clear got=%b res=%h exp=0 2", illegal, result); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    accept(4'b0000, 32'd2, 32'd3);
    wait_done(lat);
    field = 4'b1000; op_a = 32'd10; op_b = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (result !== 32'd5 || out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_%0d got=%h v=%b r=%b exp=5 1 0", i, result, out_valid, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_bubble got=v%b r%b exp=v0 r1", out_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd7) begin failures++; $display("FAIL bp_next got=v%b %h exp=v1 7", out_valid, result); end
    release_result();
  endtask

  task automatic test_flush();
    logic saw;
    accept(4'b0001, 32'h1, 32'd10);
    tick();
    tick();
    flush = 1'b1; in_valid = 1'b1; field = 4'b0000; op_a = 32'h9; op_b = 32'h9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_idle got=r%b v%b exp=r1 v0", in_ready, out_valid); end
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      saw |= out_valid | ~in_ready;
      tick();
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL flush_quiet got=%b exp=0", saw); end
  endtask

  task automatic test_rst_mid_shift();
    accept(4'b1101, 32'h8000_0000, 32'd20);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (result !== 32'h0 || zero !== 1'b1) begin failures++; $display("FAIL rst_mid_result got=%h z=%b exp=0 z=1", result, zero); end
    checks++; if ({lt, ltu, illegal, out_valid, in_ready} !== 5'b00001) begin failures++; $display("FAIL rst_mid_flags got=%b exp=00001", {lt, ltu, illegal, out_valid, in_ready}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_after got=v%b r%b exp=v0 r1", out_valid, in_ready); end
  endtask

`ifdef ALU_FAST_SHIFT_EN
  task automatic test_fast_shift();
    int lat;
    accept(4'b0001, 32'h1, 32'd31);
    wait_done(lat);
    checks++; if (result !== 32'h8000_0000 || lat !== 1) begin failures++; $display("FAIL fast_sll got=%h lat=%0d exp=80000000 lat=1", result, lat); end
    release_result();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_arith();
    test_compare();
    test_logic();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_rst_mid_shift();
`ifdef ALU_FAST_SHIFT_EN
    test_fast_shift();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
